// File: rtl/fc_2nd_sequencer.sv
// Second fully-connected layer sequencer: walks the weight RAM, and five MAC lanes
// accumulate bias + sum(W_k * activation). Each lane's sum is handed out with a Done pulse.

module fc_2nd_mac_lane #(
  parameter int Bit_width = 16,
  parameter int Acc_width = 32,
  parameter int Frac_Bits = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mac_en,
  input  logic                        first,
  input  logic                        load_res,
  input  logic signed [Bit_width-1:0] bias,
  input  logic signed [Bit_width-1:0] w,
  input  logic signed [Bit_width-1:0] act,
  output logic signed [Acc_width-1:0] result
);
  logic signed [2*Bit_width-1:0] prod;
  logic signed [Acc_width-1:0]   prod_ext, bias_ext, acc;

  assign prod     = (2*Bit_width)'(w) * (2*Bit_width)'(act);
  assign prod_ext = Acc_width'(prod);
  assign bias_ext = Acc_width'(bias) <<< Frac_Bits;

  // The first consumed index seeds the accumulator with the aligned bias.
  // The sum wraps freely and is not saturated.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (mac_en)   acc    <= (first ? bias_ext : acc) + prod_ext;
      if (load_res) result <= acc;
    end
  end
endmodule

module fc_2nd_sequencer #(
  parameter int Bit_width = 16,
  parameter int RAM_Depth = 10,
  parameter int Acc_width = 32,
  parameter int Frac_Bits = 8
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic [3:0]                  In_Len,
  output logic                        RAM_Enable,
  output logic [3:0]                  RAM_Width,
  output logic [3:0]                  Act_Addr,
  input  logic signed [Bit_width-1:0] W_Bias,
  input  logic signed [Bit_width-1:0] W_1,
  input  logic signed [Bit_width-1:0] W_2,
  input  logic signed [Bit_width-1:0] W_3,
  input  logic signed [Bit_width-1:0] W_4,
  input  logic signed [Bit_width-1:0] W_5,
  input  logic signed [Bit_width-1:0] Act_Data,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Err,
  output logic signed [Acc_width-1:0] Result_1,
  output logic signed [Acc_width-1:0] Result_2,
  output logic signed [Acc_width-1:0] Result_3,
  output logic signed [Acc_width-1:0] Result_4,
  output logic signed [Acc_width-1:0] Result_5
);
  localparam int NUM_LANES = 5;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t     state;
  logic [3:0] len, cnt;
  logic       len_ok;

  logic [NUM_LANES-1:0][Bit_width-1:0] w_lane;
  logic [NUM_LANES-1:0][Acc_width-1:0] res_lane;

  assign len_ok   = (In_Len != 4'd0) && (int'(In_Len) <= RAM_Depth);
  assign Act_Addr = RAM_Width;
  assign w_lane   = {W_5, W_4, W_3, W_2, W_1};

  // cnt is the index consumed on the current RUN edge, one behind the issued index.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= IDLE;
      len        <= '0;
      cnt        <= '0;
      RAM_Enable <= 1'b0;
      RAM_Width  <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          if (len_ok) begin
            len        <= In_Len;
            cnt        <= '0;
            RAM_Enable <= 1'b1;
            RAM_Width  <= '0;
            Busy       <= 1'b1;
            state      <= RUN;
          end else begin
            Err <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + 4'd1;
          if (4'(cnt + 4'd1) < len) begin
            RAM_Width  <= cnt + 4'd1;
            RAM_Enable <= 1'b1;
          end else begin
            RAM_Enable <= 1'b0;
          end
          if (cnt == len - 4'd1) state <= FINISH;
        end
        FINISH: begin
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fc_2nd_mac_lane #(
      .Bit_width(Bit_width),
      .Acc_width(Acc_width),
      .Frac_Bits(Frac_Bits)
    ) u_lane (
      .clk     (CLK),
      .reset   (Reset),
      .mac_en  (state == RUN),
      .first   (cnt == 4'd0),
      .load_res(state == FINISH),
      .bias    (W_Bias),
      .w       (w_lane[l]),
      .act     (Act_Data),
      .result  (res_lane[l])
    );
  end

  assign Result_1 = res_lane[0];
  assign Result_2 = res_lane[1];
  assign Result_3 = res_lane[2];
  assign Result_4 = res_lane[3];
  assign Result_5 = res_lane[4];
endmodule

// File: tb/tb_fc_2nd_sequencer.sv
// Bench for fc_2nd_sequencer: a behavioural weight RAM/activation buffer plus a
// result scoreboard filled at Start and drained at Done.

module tb_fc_2nd_sequencer;
  logic               CLK = 1'b0;
  logic               Reset, Start;
  logic [3:0]         In_Len;
  logic               RAM_Enable, Busy, Done, Err;
  logic [3:0]         RAM_Width, Act_Addr;
  logic signed [15:0] W_Bias, W_1, W_2, W_3, W_4, W_5, Act_Data;
  logic signed [31:0] Result_1, Result_2, Result_3, Result_4, Result_5;

  fc_2nd_sequencer dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .In_Len(In_Len),
    .RAM_Enable(RAM_Enable), .RAM_Width(RAM_Width), .Act_Addr(Act_Addr),
    .W_Bias(W_Bias), .W_1(W_1), .W_2(W_2), .W_3(W_3), .W_4(W_4), .W_5(W_5),
    .Act_Data(Act_Data), .Busy(Busy), .Done(Done), .Err(Err),
    .Result_1(Result_1), .Result_2(Result_2), .Result_3(Result_3),
    .Result_4(Result_4), .Result_5(Result_5)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic [4:0][31:0] r; } exp_t;
  exp_t sb_q[$];

  int checks = 0, failures = 0;
  logic signed [15:0] wtab [5][10];
  logic signed [15:0] atab [10];
  logic signed [15:0] bias_v;
  logic signed [31:0] last_res [5];
  logic signed [31:0] res_w [5];

  assign res_w[0] = Result_1;
  assign res_w[1] = Result_2;
  assign res_w[2] = Result_3;
  assign res_w[3] = Result_4;
  assign res_w[4] = Result_5;

  // RAM and activation buffer both present data on the negedge after the index is issued.
  always @(negedge CLK) begin
    if (RAM_Enable && RAM_Width < 4'd10) begin
      W_Bias   = bias_v;
      W_1      = wtab[0][RAM_Width];
      W_2      = wtab[1][RAM_Width];
      W_3      = wtab[2][RAM_Width];
      W_4      = wtab[3][RAM_Width];
      W_5      = wtab[4][RAM_Width];
      Act_Data = atab[RAM_Width];
    end else begin
      W_Bias = '0; W_1 = '0; W_2 = '0; W_3 = '0; W_4 = '0; W_5 = '0; Act_Data = '0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int len);
    exp_t   e;
    longint s;
    for (int k = 0; k < 5; k++) begin
      s = longint'(bias_v) * 256;
      for (int i = 0; i < len; i++) s += longint'(wtab[k][i]) * longint'(atab[i]);
      e.r[k] = s[31:0];
    end
    return e;
  endfunction

  task automatic cmp_results(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, sb_q.size() > 0, 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("%s_result%0d", tag, k + 1), res_w[k], $signed(e.r[k]));
        last_res[k] = e.r[k];
      end
    end
  endtask

  // hold: number of post-acceptance samples during which Start stays high.
  task automatic run_pass(input string tag, input int len, input int hold);
    int done_k, busy_n;
    sb_q.push_back(model(len));
    Start = 1'b1; In_Len = 4'(len);
    @(posedge CLK); #1;
    done_k = -1; busy_n = 0;
    for (int k = 0; k < len + 8 && done_k < 0; k++) begin
      if (k >= hold) Start = 1'b0;
      chk($sformatf("%s_en_k%0d", tag, k), RAM_Enable, k < len);
      if (k < len) begin
        chk($sformatf("%s_width_k%0d", tag, k), RAM_Width, k);
        chk($sformatf("%s_actaddr_k%0d", tag, k), Act_Addr, k);
      end
      if (Busy) busy_n++;
      if (Done) begin
        done_k = k;
        cmp_results(tag);
      end
      @(posedge CLK); #1;
    end
    Start = 1'b0;
    chk({tag, "_done_latency"}, done_k, len + 1);
    chk({tag, "_busy_cycles"}, busy_n, len + 1);
    chk({tag, "_done_one_pulse"}, Done, 0);
  endtask

  task automatic fill_tables(input int seed);
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 10; i++) wtab[k][i] = 16'((k + 1) * 997 - i * 321 + seed * 13 - 2500);
    for (int i = 0; i < 10; i++) atab[i] = 16'(i * 57 - 200 + seed);
  endtask

  initial begin
    int dn, saw_done;
    Reset = 1'b1; Start = 1'b0; In_Len = '0; bias_v = '0;
    fill_tables(0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_err", Err, 0);
    chk("rst_en", RAM_Enable, 0);
    chk("rst_width", RAM_Width, 0);
    chk("rst_actaddr", Act_Addr, 0);
    for (int k = 0; k < 5; k++) chk($sformatf("rst_result%0d", k + 1), res_w[k], 0);
    Reset = 1'b0;
    @(posedge CLK); #1;

    // Single-input pass.
    fill_tables(1);
    bias_v = 16'sd29; atab[0] = 16'sd256;
    wtab[0][0] = -16'sd316; wtab[1][0] = 16'sd267;
    run_pass("len1", 1, 0);
    chk("len1_r1_value", last_res[0], -73472);
    chk("len1_r2_value", last_res[1], 75776);

    // Four inputs with known neuron-1 sum.
    fill_tables(2);
    bias_v = 16'sd29;
    for (int i = 0; i < 4; i++) atab[i] = 16'(i + 1);
    wtab[0][0] = -16'sd316; wtab[0][1] = 16'sd267; wtab[0][2] = -16'sd359; wtab[0][3] = -16'sd297;
    run_pass("len4", 4, 0);
    chk("len4_r1_value", last_res[0], 5377);

    // Illegal lengths are rejected with an Err pulse.
    Start = 1'b1; In_Len = 4'd0;
    @(posedge CLK); #1;
    chk("len0_err", Err, 1);
    chk("len0_busy", Busy, 0);
    chk("len0_en", RAM_Enable, 0);
    chk("len0_result1_kept", Result_1, last_res[0]);
    In_Len = 4'd11;
    @(posedge CLK); #1;
    chk("len11_err", Err, 1);
    chk("len11_busy", Busy, 0);
    chk("len11_en", RAM_Enable, 0);
    chk("len11_result1_kept", Result_1, last_res[0]);
    Start = 1'b0;
    @(posedge CLK); #1;
    chk("err_one_pulse", Err, 0);

    // Start held through RUN is ignored.
    fill_tables(3);
    bias_v = -16'sd77;
    run_pass("start_in_run", 3, 3);
    saw_done = 0;
    repeat (4) begin
      if (Done) saw_done++;
      @(posedge CLK); #1;
    end
    chk("start_in_run_no_extra_done", saw_done, 0);

    // Reset asserted at T0+2 aborts the pass.
    fill_tables(4);
    bias_v = 16'sd5;
    Start = 1'b1; In_Len = 4'd4;
    @(posedge CLK); #1;
    Start = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    chk("abort_en", RAM_Enable, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_width", RAM_Width, 0);
    for (int k = 0; k < 5; k++) chk($sformatf("abort_result%0d", k + 1), res_w[k], 0);
    saw_done = 0;
    repeat (8) begin
      if (Done) saw_done++;
      @(posedge CLK); #1;
    end
    chk("abort_no_done", saw_done, 0);
    run_pass("after_abort", 5, 0);

    // Full-scale products wrap at 32 bits.
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 10; i++) wtab[k][i] = 16'sd32767;
    for (int i = 0; i < 10; i++) atab[i] = 16'sd32767;
    bias_v = '0;
    run_pass("wrap", 10, 0);
    chk("wrap_r1_value", last_res[0], 2146828298);

    // Start held continuously: one pass every len+2 cycles.
    fill_tables(5);
    bias_v = 16'sd100;
    repeat (3) sb_q.push_back(model(2));
    Start = 1'b1; In_Len = 4'd2;
    @(posedge CLK); #1;
    dn = 0;
    for (int k = 0; k < 14; k++) begin
      if (k >= 8) Start = 1'b0;
      if (Done) begin
        chk($sformatf("b2b_done_at_%0d", dn), k, 3 + 4 * dn);
        dn++;
        cmp_results("b2b");
      end
      @(posedge CLK); #1;
    end
    chk("b2b_done_count", dn, 3);
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
